norm_mult_ctrl: RTL and testbench
=================================

# norm_mult_ctrl

Parametrised sequencer for the normalise–multiply–denormalise approximate multiplier datapath. It loads both operand shift registers and left-normalises each operand independently until its MSB is 1. It then waits a configurable multiplier latency, loads the KEEP×KEEP product into the result shift register, and shifts the result left or right by a computed signed amount. It adds zero-operand detection and a start/busy/done handshake, and keeps all shift counting internal.

## Interface
- WIDTH, 16: operand width in bits; must be ≥ 4.
- KEEP, 8: bits kept after normalisation (multiplier input width); 1 ≤ KEEP ≤ WIDTH.
- MULT_LAT, 0: wait cycles between normalisation and result load; 0 skips the MULT state.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- msb1, msb2  in  1  current MSB of operand shift registers 1 and 2.
- busy  out  1  high in every state except IDLE.
- load_op  out  1  load both operand shift registers from the datapath inputs.
- en_sh1, en_sh2  out  1  shift operand register 1/2 left by one, LSB fill 0.
- load_res  out  1  load the product into the result shift register.
- en_res  out  1  shift the result register by one.
- res_left  out  1  direction for en_res: 1 = left, 0 = right; 0 when en_res = 0.
- res_clr  out  1  clear the result register (zero path).
- done  out  1  one-cycle completion pulse.
- zero_flag  out  1  high with done when either operand was zero.

## Operation
- Internal registers:
  - cnt1, cnt2, each $clog2(WIDTH) bits.
  - shamt, signed, $clog2(2*WIDTH)+1 bits.
  - lat counter, $clog2(MULT_LAT+1) bits.
  - zero register.
- IDLE: if start = 1, go to LOAD. Otherwise stay. All outputs are 0.
- LOAD: load_op = 1. Clear cnt1, cnt2 and zero. Go to NORM.
- NORM: en_sh1 = !msb1 && cnt1 != WIDTH-1, and likewise for en_sh2.
  - Each counter increments in the same cycle its enable is high.
  - When en_sh1 = en_sh2 = 0, leave NORM:
    - If (msb1 = 0 and cnt1 = WIDTH-1) or (msb2 = 0 and cnt2 = WIDTH-1), set zero and go to ZERO.
    - Otherwise go to MULT, or to LOAD_RES when MULT_LAT = 0.
- MULT: hold for exactly MULT_LAT cycles, then go to LOAD_RES.
- LOAD_RES: load_res = 1. Register shamt = 2*(WIDTH-KEEP) - cnt1 - cnt2, computed at full signed width with no truncation. Go to DENORM.
- DENORM:
  - If shamt = 0, assert nothing and go to DONE.
  - Otherwise en_res = 1 and res_left = (shamt > 0). shamt moves one step toward 0.
  - Exit to DONE on the cycle where |shamt| = 1, so exactly |shamt| shift cycles occur.
- ZERO: res_clr = 1. Go to DONE.
- DONE: done = 1, and zero_flag = zero. Go to IDLE.
- The state register is one-hot. An illegal encoding recovers to IDLE on the next clock.

## Timing
- Reset:
  - State = IDLE immediately on rst (asynchronous).
  - Every output = 0; cnt1, cnt2, shamt and zero = 0.
  - Reset mid-operation abandons the operation and produces no done pulse.
- start:
  - Only start = 1 sampled in IDLE is accepted.
  - start while busy, or in the DONE cycle, is ignored.
  - start held high after done begins a new operation on the first IDLE cycle.
- Latency from the accepting clock edge to the done cycle is (1 + N + MULT_LAT + 1 + max(|shamt|,1) + 1) cycles, where N = max(cnt1, cnt2) + 1 NORM cycles.
- Zero path latency: 1 + N + 1 + 1 cycles, with no load_res and no en_res.
- Operand already normalised (msb = 1 on entry): that operand's count is 0. NORM still lasts at least 1 cycle.
- Outputs are Moore-decoded from state, except en_sh1/en_sh2 and res_left, which also depend on msb and shamt inputs within the same state.

## Test plan
- WIDTH=16, KEEP=8, MULT_LAT=0; op1 = op2 = 0x8000.
  - Expect: cnt 0/0, 1 NORM cycle, shamt = +16, 16 cycles of en_res with res_left = 1.
  - done 20 cycles after the accepting edge; zero_flag = 0.
- op1 = 0x0003, op2 = 0x0005.
  - Expect: en_sh1 for 14 cycles and en_sh2 for 13, 15 NORM cycles.
  - shamt = -11, so 11 right shifts (res_left = 0); then done.
- op1 = 0x0000, op2 = 0x0005.
  - Expect: cnt1 reaches 15, 16 NORM cycles, then ZERO with res_clr = 1.
  - done with zero_flag = 1; load_res and en_res are never asserted.
- MULT_LAT=3, op1 = 0x00FF, op2 = 0x0100.
  - Expect: cnt 8/7, exactly 3 MULT cycles between NORM exit and load_res.
  - shamt = +1, giving 1 left shift.
- Handshake:
  - start pulsed during DENORM is ignored, with no second operation.
  - rst asserted mid-NORM: all outputs drop to 0 asynchronously, and no done pulse appears.
  - A start after rst release runs a complete, correct operation.
- Back-to-back: start held high continuously.
  - Expect: DONE → IDLE → LOAD, busy low for exactly one cycle, two correct done pulses.

Source files
------------

// File: rtl/norm_mult_ctrl.sv
// Sequencer for the normalise-multiply-denormalise approximate multiplier.
// Steers operand/result shift registers and counts all shift amounts internally.
module norm_mult_ctrl #(
  parameter int WIDTH    = 16,
  parameter int KEEP     = 8,
  parameter int MULT_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic msb1,
  input  logic msb2,
  output logic busy,
  output logic load_op,
  output logic en_sh1,
  output logic en_sh2,
  output logic load_res,
  output logic en_res,
  output logic res_left,
  output logic res_clr,
  output logic done,
  output logic zero_flag
);

  localparam int CW       = $clog2(WIDTH);
  localparam int SW       = $clog2(2 * WIDTH) + 1;
  localparam int LW       = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;
  localparam int LAT_LAST = (MULT_LAT > 0) ? MULT_LAT - 1 : 0;

  localparam logic [CW-1:0]        CNT_MAX = CW'(WIDTH - 1);
  localparam logic signed [SW-1:0] SH_BASE = SW'(2 * (WIDTH - KEEP));
  localparam logic signed [SW-1:0] SH_ONE  = SW'(1);
  localparam logic signed [SW-1:0] SH_MONE = '1;

  localparam logic [7:0] S_IDLE     = 8'b0000_0001;
  localparam logic [7:0] S_LOAD     = 8'b0000_0010;
  localparam logic [7:0] S_NORM     = 8'b0000_0100;
  localparam logic [7:0] S_MULT     = 8'b0000_1000;
  localparam logic [7:0] S_LOAD_RES = 8'b0001_0000;
  localparam logic [7:0] S_DENORM   = 8'b0010_0000;
  localparam logic [7:0] S_ZERO     = 8'b0100_0000;
  localparam logic [7:0] S_DONE     = 8'b1000_0000;

  logic [7:0]           state;
  logic [7:0]           state_nxt;
  logic [CW-1:0]        cnt1;
  logic [CW-1:0]        cnt2;
  logic signed [SW-1:0] shamt;
  logic signed [SW-1:0] shamt_calc;
  logic [LW-1:0]        lat;
  logic                 zero;
  logic                 zero_det;
  logic                 norm_idle;
  logic                 sh_last;
  logic                 sh_pos;

  // An operand that still shows MSB=0 after WIDTH-1 shifts was all zeros.
  assign zero_det  = (!msb1 && (cnt1 == CNT_MAX)) || (!msb2 && (cnt2 == CNT_MAX));
  assign norm_idle = !en_sh1 && !en_sh2;

  assign shamt_calc = SH_BASE
                    - $signed({{(SW-CW){1'b0}}, cnt1})
                    - $signed({{(SW-CW){1'b0}}, cnt2});

  assign sh_last = (shamt == SH_ONE) || (shamt == SH_MONE);
  assign sh_pos  = !shamt[SW-1] && (shamt != '0);

  assign busy      = (state != S_IDLE);
  assign load_op   = (state == S_LOAD);
  assign en_sh1    = (state == S_NORM) && !msb1 && (cnt1 != CNT_MAX);
  assign en_sh2    = (state == S_NORM) && !msb2 && (cnt2 != CNT_MAX);
  assign load_res  = (state == S_LOAD_RES);
  assign en_res    = (state == S_DENORM) && (shamt != '0);
  assign res_left  = en_res && sh_pos;
  assign res_clr   = (state == S_ZERO);
  assign done      = (state == S_DONE);
  assign zero_flag = done && zero;

  // Any encoding that is not one of the one-hot states falls back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:     state_nxt = start ? S_LOAD : S_IDLE;
      S_LOAD:     state_nxt = S_NORM;
      S_NORM: begin
        if (!norm_idle)
          state_nxt = S_NORM;
        else if (zero_det)
          state_nxt = S_ZERO;
        else if (MULT_LAT == 0)
          state_nxt = S_LOAD_RES;
        else
          state_nxt = S_MULT;
      end
      S_MULT:     state_nxt = (lat == LW'(LAT_LAST)) ? S_LOAD_RES : S_MULT;
      S_LOAD_RES: state_nxt = S_DENORM;
      S_DENORM:   state_nxt = ((shamt == '0) || sh_last) ? S_DONE : S_DENORM;
      S_ZERO:     state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt1  <= '0;
      cnt2  <= '0;
      shamt <= '0;
      lat   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          cnt1 <= '0;
          cnt2 <= '0;
          zero <= 1'b0;
        end
        S_NORM: begin
          if (en_sh1)
            cnt1 <= cnt1 + CW'(1);
          if (en_sh2)
            cnt2 <= cnt2 + CW'(1);
          if (norm_idle && zero_det)
            zero <= 1'b1;
          lat <= '0;
        end
        S_MULT:     lat <= lat + LW'(1);
        S_LOAD_RES: shamt <= shamt_calc;
        // Step the remaining shift amount one unit toward zero per result shift.
        S_DENORM: begin
          if (sh_pos)
            shamt <= shamt - SH_ONE;
          else if (shamt != '0)
            shamt <= shamt + SH_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_mult_ctrl.sv
// Scoreboard bench for norm_mult_ctrl: two instances (MULT_LAT 0 and 3) driven
// by a behavioural operand shift-register model.
module tb_norm_mult_ctrl;

  localparam int WIDTH = 16;
  localparam int KEEP  = 8;

  typedef struct {
    int inst;
    int lat;
    int nsh1;
    int nsh2;
    int nload;
    int load_cyc;
    int nleft;
    int nright;
    int nclr;
    int zflag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start, msb1, msb2;
  logic [1:0] busy, load_op, en_sh1, en_sh2, load_res, en_res, res_left, res_clr, done, zero_flag;
  logic [WIDTH-1:0] op1 [2];
  logic [WIDTH-1:0] op2 [2];
  logic [WIDTH-1:0] sh1 [2];
  logic [WIDTH-1:0] sh2 [2];

  exp_t exp_q [$];
  int   mlat [2] = '{0, 3};
  int   checks = 0;
  int   errors = 0;
  int   stray  = 0;
  bit   active [2];
  int   cyc [2], nsh1 [2], nsh2 [2], nload [2], load_cyc [2], nleft [2], nright [2], nclr [2];

  always #5 clk = ~clk;

  norm_mult_ctrl #(.WIDTH(WIDTH), .KEEP(KEEP), .MULT_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .msb1(msb1[0]), .msb2(msb2[0]),
    .busy(busy[0]), .load_op(load_op[0]), .en_sh1(en_sh1[0]), .en_sh2(en_sh2[0]),
    .load_res(load_res[0]), .en_res(en_res[0]), .res_left(res_left[0]),
    .res_clr(res_clr[0]), .done(done[0]), .zero_flag(zero_flag[0])
  );

  norm_mult_ctrl #(.WIDTH(WIDTH), .KEEP(KEEP), .MULT_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .msb1(msb1[1]), .msb2(msb2[1]),
    .busy(busy[1]), .load_op(load_op[1]), .en_sh1(en_sh1[1]), .en_sh2(en_sh2[1]),
    .load_res(load_res[1]), .en_res(en_res[1]), .res_left(res_left[1]),
    .res_clr(res_clr[1]), .done(done[1]), .zero_flag(zero_flag[1])
  );

  assign msb1 = {sh1[1][WIDTH-1], sh1[0][WIDTH-1]};
  assign msb2 = {sh2[1][WIDTH-1], sh2[0][WIDTH-1]};

  // Operand shift registers the controller steers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        sh1[g] <= '0;
        sh2[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (load_op[g])
          sh1[g] <= op1[g];
        else if (en_sh1[g])
          sh1[g] <= sh1[g] << 1;
        if (load_op[g])
          sh2[g] <= op2[g];
        else if (en_sh2[g])
          sh2[g] <= sh2[g] << 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lzCount(input logic [WIDTH-1:0] v);
    int c = 0;
    for (int i = WIDTH - 1; i > 0; i--) begin
      if (v[i])
        break;
      c++;
    end
    return c;
  endfunction

  function automatic int outs(input int g);
    return int'({busy[g], load_op[g], en_sh1[g], en_sh2[g], load_res[g],
                 en_res[g], res_left[g], res_clr[g], done[g], zero_flag[g]});
  endfunction

  task automatic pushExpect(input int g, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int c1, c2, n, s, mag;
    c1 = lzCount(a);
    c2 = lzCount(b);
    n  = ((c1 > c2) ? c1 : c2) + 1;
    s  = 2 * (WIDTH - KEEP) - c1 - c2;
    mag = (s < 0) ? -s : s;
    e.inst = g;
    e.nsh1 = c1;
    e.nsh2 = c2;
    if (a == '0 || b == '0) begin
      e.zflag = 1; e.nclr = 1; e.nload = 0; e.load_cyc = 0;
      e.nleft = 0; e.nright = 0;
      e.lat = 1 + n + 1 + 1;
    end else begin
      e.zflag = 0; e.nclr = 0; e.nload = 1;
      e.load_cyc = 1 + n + mlat[g] + 1;
      e.nleft  = (s > 0) ? s : 0;
      e.nright = (s < 0) ? -s : 0;
      e.lat = e.load_cyc + ((mag > 1) ? mag : 1) + 1;
    end
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 with the target instance idle.
  task automatic applyStimulus(input int g, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit hold);
    pushExpect(g, a, b);
    op1[g] = a;
    op2[g] = b;
    start[g] = 1'b1;
    if (!hold) begin
      @(posedge clk);
      #1 start[g] = 1'b0;
    end
  endtask

  task automatic waitDone(input int g, input int maxc);
    int n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (done[g])
        break;
    end
    checkOutput("done_seen", int'(done[g]), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: accumulates per-operation activity and pops the scoreboard on done.
  initial begin
    exp_t e;
    for (int g = 0; g < 2; g++)
      active[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          active[g] = 1'b0;
        end else begin
          if (active[g]) begin
            cyc[g]++;
            if (en_sh1[g]) nsh1[g]++;
            if (en_sh2[g]) nsh2[g]++;
            if (load_res[g]) begin
              nload[g]++;
              load_cyc[g] = cyc[g];
            end
            if (en_res[g] && res_left[g]) nleft[g]++;
            if (en_res[g] && !res_left[g]) nright[g]++;
            if (res_clr[g]) nclr[g]++;
            if (res_left[g] && !en_res[g]) stray++;
            if (zero_flag[g] && !done[g]) stray++;
            if (done[g]) begin
              active[g] = 1'b0;
              if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                stray++;
              end else begin
                e = exp_q.pop_front();
                checkOutput("latency", cyc[g], e.lat);
                checkOutput("en_sh1_count", nsh1[g], e.nsh1);
                checkOutput("en_sh2_count", nsh2[g], e.nsh2);
                checkOutput("load_res_count", nload[g], e.nload);
                checkOutput("load_res_cycle", load_cyc[g], e.load_cyc);
                checkOutput("left_shifts", nleft[g], e.nleft);
                checkOutput("right_shifts", nright[g], e.nright);
                checkOutput("res_clr_count", nclr[g], e.nclr);
                checkOutput("zero_flag", int'(zero_flag[g]), e.zflag);
              end
            end
          end else if (outs(g) != 0) begin
            stray++;
          end
          if (!busy[g] && start[g]) begin
            active[g] = 1'b1;
            cyc[g] = 0; nsh1[g] = 0; nsh2[g] = 0; nload[g] = 0; load_cyc[g] = 0;
            nleft[g] = 0; nright[g] = 0; nclr[g] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    int nd;
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1;
    start = '0;
    for (int g = 0; g < 2; g++) begin
      op1[g] = '0;
      op2[g] = '0;
    end
    #12;
    checkOutput("reset_outputs0", outs(0), 0);
    checkOutput("reset_outputs1", outs(1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_outputs0", outs(0), 0);
    @(posedge clk);
    #1;

    // Directed operations on the zero-latency instance.
    applyStimulus(0, 16'h8000, 16'h8000, 1'b0); waitDone(0, 100);
    applyStimulus(0, 16'h0003, 16'h0005, 1'b0); waitDone(0, 100);
    applyStimulus(0, 16'h0000, 16'h0005, 1'b0); waitDone(0, 100);
    applyStimulus(0, 16'h0080, 16'h0080, 1'b0); waitDone(0, 100);
    applyStimulus(0, 16'h0001, 16'hFFFF, 1'b0); waitDone(0, 100);

    // MULT_LAT = 3 instance.
    applyStimulus(1, 16'h00FF, 16'h0100, 1'b0); waitDone(1, 100);
    applyStimulus(1, 16'h1234, 16'h0000, 1'b0); waitDone(1, 100);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      applyStimulus(i % 2, ra, rb, 1'b0);
      waitDone(i % 2, 100);
    end

    // start pulsed during DENORM must be ignored.
    applyStimulus(0, 16'h8000, 16'h8000, 1'b0);
    repeat (6) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    waitDone(0, 100);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy[0] || done[0]) nd++;
    end
    checkOutput("no_second_op", nd, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of NORM.
    applyStimulus(0, 16'h0003, 16'h0005, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    void'(exp_q.pop_front());
    #1 checkOutput("reset_midop_outputs", outs(0), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    checkOutput("no_done_after_reset", nd, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 16'h00FF, 16'h0100, 1'b0); waitDone(0, 100);

    // Back-to-back with start held high.
    applyStimulus(0, 16'h8000, 16'h8000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    op1[0] = 16'h0003;
    op2[0] = 16'h0005;
    pushExpect(0, 16'h0003, 16'h0005);
    waitDone(0, 100);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy[0]) break;
      gap++;
    end
    checkOutput("idle_gap", gap, 1);
    waitDone(0, 100);
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    checkOutput("stray_activity", stray, 0);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
